// File: rtl/pipe_stage_reg.sv
// Parametrised pipeline-stage register with valid/ready handshake.
// Optional two-entry skid buffer makes in_ready come from a register.
module pipe_stage_reg #(
  parameter int CTRL_WIDTH = 8,
  parameter int DATA_WIDTH = 108,
  parameter int SKID       = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  is_hold,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [CTRL_WIDTH-1:0] in_ctrl,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [CTRL_WIDTH-1:0] out_ctrl,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [1:0]            occupancy
);

  localparam bit USE_SKID = (SKID != 0);

  logic                  main_valid;
  logic [CTRL_WIDTH-1:0] main_ctrl;
  logic [DATA_WIDTH-1:0] main_data;
  logic                  skid_valid;
  logic [CTRL_WIDTH-1:0] skid_ctrl;
  logic [DATA_WIDTH-1:0] skid_data;

  logic gate;
  logic push;
  logic pop;

  assign gate = ~rst & ~is_hold & ~flush;

  generate
    if (USE_SKID) begin : g_rdy_skid
      assign in_ready = gate & ~skid_valid;
    end else begin : g_rdy_flat
      assign in_ready = gate & (~main_valid | out_ready);
    end
  endgenerate

  assign push = in_valid & in_ready;
  assign pop  = main_valid & out_ready & ~is_hold;

  // Head/skid state update: rst > flush > hold > handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      main_valid <= 1'b0;
      main_ctrl  <= '0;
      main_data  <= '0;
      skid_valid <= 1'b0;
      skid_ctrl  <= '0;
      skid_data  <= '0;
    end else if (flush) begin
      main_valid <= 1'b0;
      main_ctrl  <= '0;
      skid_valid <= 1'b0;
      skid_ctrl  <= '0;
    end else if (!is_hold) begin
      if (USE_SKID && pop && skid_valid) begin
        main_valid <= 1'b1;
        main_ctrl  <= skid_ctrl;
        main_data  <= skid_data;
        skid_valid <= 1'b0;
      end else if (push && (!main_valid || pop)) begin
        main_valid <= 1'b1;
        main_ctrl  <= in_ctrl;
        main_data  <= in_data;
      end else if (USE_SKID && push) begin
        skid_valid <= 1'b1;
        skid_ctrl  <= in_ctrl;
        skid_data  <= in_data;
      end else if (pop) begin
        main_valid <= 1'b0;
      end
    end
  end

  // Bubbles carry zero control so downstream enables stay off.
  always_comb begin
    out_valid = main_valid;
    out_ctrl  = main_valid ? main_ctrl : '0;
    out_data  = main_data;
    occupancy = {1'b0, main_valid} + {1'b0, skid_valid};
  end

endmodule
